// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and sweep FSM state type for the multi-port register file.
package regfile_pkg;
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    typedef enum logic {ST_IDLE, ST_SWEEP} state_t;
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: decode/writeback-facing bus of the register file (master = core, slave = regfile).
interface regfile_mp_if #(
    parameter int XLEN  = regfile_pkg::XLEN_DEF,
    parameter int NREGS = regfile_pkg::NREGS_DEF
);
    localparam int AW = $clog2(NREGS);
    logic            we0;
    logic [AW-1:0]   waddr0;
    logic [XLEN-1:0] wdata0;
    logic            we1;
    logic [AW-1:0]   waddr1;
    logic [XLEN-1:0] wdata1;
    logic [AW-1:0]   raddr_a;
    logic [XLEN-1:0] rdata_a;
    logic            busy_a;
    logic [AW-1:0]   raddr_b;
    logic [XLEN-1:0] rdata_b;
    logic            busy_b;
    logic            sb_set;
    logic [AW-1:0]   sb_addr;
    logic            clr_req;
    logic            clr_busy;
    logic [AW-1:0]   dbg_addr;
    logic [XLEN-1:0] dbg_data;
    modport master (
        output we0, waddr0, wdata0, we1, waddr1, wdata1, raddr_a, raddr_b,
               sb_set, sb_addr, clr_req, dbg_addr,
        input  rdata_a, busy_a, rdata_b, busy_b, clr_busy, dbg_data
    );
    modport slave (
        input  we0, waddr0, wdata0, we1, waddr1, wdata1, raddr_a, raddr_b,
               sb_set, sb_addr, clr_req, dbg_addr,
        output rdata_a, busy_a, rdata_b, busy_b, clr_busy, dbg_data
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits; set beats clear, sweep clears one entry per cycle.
module regfile_scoreboard #(
    parameter int NREGS = 32,
    localparam int AW = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set,
    input  logic [AW-1:0] set_addr,
    input  logic          clr0,
    input  logic [AW-1:0] clr0_addr,
    input  logic          clr1,
    input  logic [AW-1:0] clr1_addr,
    input  logic          sweep,
    input  logic [AW-1:0] sweep_idx,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic          busy_a,
    output logic          busy_b
);
    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);
    logic [NREGS-1:0] busy_q, busy_d;
    always_comb begin
        busy_d = busy_q;
        if (clr0) busy_d[clr0_addr] = 1'b0;
        if (clr1) busy_d[clr1_addr] = 1'b0;
        if (sweep) busy_d[sweep_idx] = 1'b0;
        if (set) busy_d[set_addr] = 1'b1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else busy_q <= busy_d;
    end
    assign busy_a = ({1'b0, raddr_a} < NREGS_W) && busy_q[raddr_a];
    assign busy_b = ({1'b0, raddr_b} < NREGS_W) && busy_q[raddr_b];
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: 2W/2R register file with scoreboard, clear sweep and registered debug port.
// Optional same-cycle write-to-read forwarding under `define REGFILE_BYPASS_EN.
module regfile_mp import regfile_pkg::*; #(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    localparam logic [AW:0]   NREGS_W = (AW+1)'(NREGS);
    localparam logic [AW-1:0] LAST    = AW'(NREGS - 1);

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < NREGS_W;
    endfunction

    function automatic logic wr_ok(input logic [AW-1:0] a);
        return a != '0 && in_range(a);
    endfunction

    state_t          state_q;
    logic [AW-1:0]   idx_q;
    logic            clr_busy_q;
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [XLEN-1:0] dbg_data_q, dbg_data_d;
    logic            sweep, w0_ok, w1_ok, sb_busy_a, sb_busy_b;
    logic [XLEN-1:0] rd_a, rd_b;

    assign sweep = state_q == ST_SWEEP;
    assign w0_ok = bus.we0 && wr_ok(bus.waddr0) && !sweep;
    assign w1_ok = bus.we1 && wr_ok(bus.waddr1) && !sweep;

    // Port 1 is applied last so it wins a same-address collision.
    always_comb begin
        regs_d = regs_q;
        if (w0_ok) regs_d[bus.waddr0] = bus.wdata0;
        if (w1_ok) regs_d[bus.waddr1] = bus.wdata1;
        if (sweep) regs_d[idx_q] = '0;
        regs_d[0] = '0;
    end

    assign dbg_data_d = in_range(bus.dbg_addr) ? regs_q[bus.dbg_addr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q     <= '{default: '0};
            dbg_data_q <= '0;
        end else begin
            regs_q     <= regs_d;
            dbg_data_q <= dbg_data_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= AW'(1);
            clr_busy_q <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (bus.clr_req) begin
                state_q    <= ST_SWEEP;
                idx_q      <= AW'(1);
                clr_busy_q <= 1'b1;
            end
        end else if (idx_q == LAST) begin
            state_q    <= ST_IDLE;
            idx_q      <= AW'(1);
            clr_busy_q <= 1'b0;
        end else begin
            idx_q <= idx_q + AW'(1);
        end
    end

    regfile_scoreboard #(.NREGS(NREGS)) u_sb (
        .clk       (clk),
        .rst       (rst),
        .set       (bus.sb_set && wr_ok(bus.sb_addr) && !sweep),
        .set_addr  (bus.sb_addr),
        .clr0      (w0_ok),
        .clr0_addr (bus.waddr0),
        .clr1      (w1_ok),
        .clr1_addr (bus.waddr1),
        .sweep     (sweep),
        .sweep_idx (idx_q),
        .raddr_a   (bus.raddr_a),
        .raddr_b   (bus.raddr_b),
        .busy_a    (sb_busy_a),
        .busy_b    (sb_busy_b)
    );

    assign rd_a = in_range(bus.raddr_a) ? regs_q[bus.raddr_a] : '0;
    assign rd_b = in_range(bus.raddr_b) ? regs_q[bus.raddr_b] : '0;

`ifdef REGFILE_BYPASS_EN
    logic byp_a0, byp_a1, byp_b0, byp_b1;
    assign byp_a0 = w0_ok && bus.waddr0 == bus.raddr_a;
    assign byp_a1 = w1_ok && bus.waddr1 == bus.raddr_a;
    assign byp_b0 = w0_ok && bus.waddr0 == bus.raddr_b;
    assign byp_b1 = w1_ok && bus.waddr1 == bus.raddr_b;
    assign bus.rdata_a = byp_a1 ? bus.wdata1 : byp_a0 ? bus.wdata0 : rd_a;
    assign bus.rdata_b = byp_b1 ? bus.wdata1 : byp_b0 ? bus.wdata0 : rd_b;
    assign bus.busy_a  = sb_busy_a && !(byp_a0 || byp_a1);
    assign bus.busy_b  = sb_busy_b && !(byp_b0 || byp_b1);
`else
    assign bus.rdata_a = rd_a;
    assign bus.rdata_b = rd_b;
    assign bus.busy_a  = sb_busy_a;
    assign bus.busy_b  = sb_busy_b;
`endif

    assign bus.clr_busy = clr_busy_q;
    assign bus.dbg_data = dbg_data_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed stimulus with an expectation queue drained by a negedge monitor.
module tb_regfile_mp;
    localparam int XLEN = 32, NREGS = 32, AW = 5;
    localparam int K_RA = 0, K_BA = 1, K_RB = 2, K_BB = 3, K_CB = 4, K_DBG = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS)) bus();
    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] actual(input int kind);
        case (kind)
            K_RA:    return bus.rdata_a;
            K_BA:    return {31'b0, bus.busy_a};
            K_RB:    return bus.rdata_b;
            K_BB:    return {31'b0, bus.busy_b};
            K_CB:    return {31'b0, bus.clr_busy};
            default: return bus.dbg_data;
        endcase
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (actual(e.kind) !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, actual(e.kind), e.val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input int kind, input logic [31:0] val, input string name);
        q.push_back('{kind, val, name});
    endtask

    task automatic idle();
        bus.we0 = 1'b0; bus.we1 = 1'b0; bus.sb_set = 1'b0; bus.clr_req = 1'b0;
    endtask

    function automatic logic [31:0] fv(input int i);
        return 32'(i) * 32'h0101_0101;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        bus.waddr0 = '0; bus.wdata0 = '0; bus.waddr1 = '0; bus.wdata1 = '0;
        bus.raddr_a = AW'(5); bus.raddr_b = AW'(9); bus.sb_addr = '0; bus.dbg_addr = '0;
        #2;
        expect_v(K_RA, 0, "reset_rdata_a");
        expect_v(K_BB, 0, "reset_busy_b");
        expect_v(K_CB, 0, "reset_clr_busy");
        expect_v(K_DBG, 0, "reset_dbg");
        tick();
        rst = 1'b0;
        // basic write, read and debug latency
        tick();
        bus.we0 = 1'b1; bus.waddr0 = AW'(5); bus.wdata0 = 32'hDEAD_BEEF;
`ifdef REGFILE_BYPASS_EN
        expect_v(K_RA, 32'hDEAD_BEEF, "wr5_same_cycle_bypass");
`else
        expect_v(K_RA, 0, "wr5_same_cycle_old");
`endif
        tick();
        idle();
        bus.dbg_addr = AW'(5);
        expect_v(K_RA, 32'hDEAD_BEEF, "rd5");
        expect_v(K_DBG, 0, "dbg_latency");
        tick();
        expect_v(K_DBG, 32'hDEAD_BEEF, "dbg5");
        // dual-port collision, port 1 wins
        bus.we0 = 1'b1; bus.waddr0 = AW'(7); bus.wdata0 = 32'h11;
        bus.we1 = 1'b1; bus.waddr1 = AW'(7); bus.wdata1 = 32'h22;
        tick();
        idle();
        bus.raddr_b = AW'(7);
        expect_v(K_RB, 32'h22, "collision_p1_wins");
        bus.we0 = 1'b1; bus.waddr0 = '0; bus.wdata0 = 32'h55;
        bus.sb_set = 1'b1; bus.sb_addr = '0;
        tick();
        idle();
        bus.raddr_a = '0;
        expect_v(K_RA, 0, "reg0_reads_zero");
        expect_v(K_BA, 0, "reg0_never_busy");
        // scoreboard set / clear / set-wins
        bus.sb_set = 1'b1; bus.sb_addr = AW'(9); bus.raddr_a = AW'(9);
        tick();
        idle();
        expect_v(K_BA, 1, "sb_set9");
        bus.we0 = 1'b1; bus.waddr0 = AW'(9); bus.wdata0 = 32'h1;
        tick();
        idle();
        expect_v(K_BA, 0, "sb_clear_by_write");
        expect_v(K_RA, 32'h1, "rd9");
        bus.sb_set = 1'b1; bus.sb_addr = AW'(9);
        bus.we1 = 1'b1; bus.waddr1 = AW'(9); bus.wdata1 = 32'h2;
        tick();
        idle();
        expect_v(K_BA, 1, "sb_set_wins");
        expect_v(K_RA, 32'h2, "rd9_second");
        // same-cycle visibility on read port B
        bus.we0 = 1'b1; bus.waddr0 = AW'(3); bus.wdata0 = 32'h1111;
        tick();
        idle();
        bus.we1 = 1'b1; bus.waddr1 = AW'(3); bus.wdata1 = 32'hABCD; bus.raddr_b = AW'(3);
`ifdef REGFILE_BYPASS_EN
        expect_v(K_RB, 32'hABCD, "bypass_b");
`else
        expect_v(K_RB, 32'h1111, "no_bypass_old_b");
`endif
        tick();
        idle();
        expect_v(K_RB, 32'hABCD, "rd3_next_cycle");
        // fill every register, then sweep
        for (int i = 1; i < NREGS; i += 2) begin
            bus.we0 = 1'b1; bus.waddr0 = AW'(i); bus.wdata0 = fv(i);
            bus.we1 = (i + 1) < NREGS; bus.waddr1 = AW'(i + 1); bus.wdata1 = fv(i + 1);
            tick();
        end
        idle();
        bus.sb_set = 1'b1; bus.sb_addr = AW'(12);
        bus.raddr_a = AW'(31); bus.raddr_b = AW'(1);
        expect_v(K_RA, fv(31), "fill31");
        expect_v(K_RB, fv(1), "fill1");
        tick();
        idle();
        bus.clr_req = 1'b1;
        expect_v(K_CB, 0, "clr_busy_before_sweep");
        tick();
        bus.clr_req = 1'b0;
        for (int i = 0; i < NREGS - 1; i++) begin
            idle();
            if (i == 5) begin
                bus.we0 = 1'b1; bus.waddr0 = AW'(2); bus.wdata0 = 32'h77;
                bus.sb_set = 1'b1; bus.sb_addr = AW'(3);
            end
            if (i == 10) begin
                bus.raddr_a = AW'(5); bus.raddr_b = AW'(20);
                expect_v(K_RA, 0, "sweep_swept_reads_zero");
                expect_v(K_RB, fv(20), "sweep_unswept_keeps");
            end
            if (i == 20) bus.clr_req = 1'b1;
            expect_v(K_CB, 1, "clr_busy_during_sweep");
            tick();
        end
        idle();
        expect_v(K_CB, 0, "clr_busy_after_sweep");
        for (int j = 1; j < NREGS; j++) begin
            bus.raddr_a = AW'(j); bus.raddr_b = AW'(j);
            expect_v(K_RA, 0, "post_sweep_zero");
            expect_v(K_BB, 0, "post_sweep_not_busy");
            tick();
        end
        // reset in the middle of a sweep
        bus.we0 = 1'b1; bus.waddr0 = AW'(25); bus.wdata0 = 32'h25;
        bus.sb_set = 1'b1; bus.sb_addr = AW'(26);
        tick();
        idle();
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            expect_v(K_CB, 1, "clr_busy_before_reset");
            tick();
        end
        rst = 1'b1;
        #1;
        bus.raddr_a = AW'(25); bus.raddr_b = AW'(26);
        expect_v(K_CB, 0, "reset_mid_sweep_clr_busy");
        expect_v(K_RA, 0, "reset_mid_sweep_reg");
        expect_v(K_BB, 0, "reset_mid_sweep_busy");
        tick();
        rst = 1'b0;
        bus.we0 = 1'b1; bus.waddr0 = AW'(1); bus.wdata0 = 32'hAA;
        bus.we1 = 1'b1; bus.waddr1 = AW'(2); bus.wdata1 = 32'hBB;
        tick();
        idle();
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        bus.raddr_a = AW'(1);
        expect_v(K_RA, 32'hAA, "restart_idx1_not_yet");
        expect_v(K_CB, 1, "restart_clr_busy");
        tick();
        bus.raddr_b = AW'(2);
        expect_v(K_RA, 0, "restart_idx1_cleared");
        expect_v(K_RB, 32'hBB, "restart_idx2_pending");
        for (int i = 1; i < NREGS - 1; i++) begin
            expect_v(K_CB, 1, "restart_sweep_len");
            tick();
        end
        expect_v(K_CB, 0, "restart_sweep_end");
        tick();
        for (int k = 0; k < 5 && q.size() > 0; k++) tick();
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the pipelined core.
- Provides two write ports, two combinational read ports and a per-register scoreboard (busy bits) for hazard detection.
- Includes a sequential clear-sweep engine and a registered debug readout port.
- Sits between the decode stage (read, scoreboard set) and the writeback stage (writes, scoreboard clear).

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (>=2; need not be a power of 2)
AW, $clog2(NREGS), address width (derived localparam, not overridable)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
we0  in  1  write enable, port 0
waddr0  in  AW  write address, port 0
wdata0  in  XLEN  write data, port 0
we1  in  1  write enable, port 1
waddr1  in  AW  write address, port 1
wdata1  in  XLEN  write data, port 1
raddr_a  in  AW  read address A
rdata_a  out  XLEN  read data A (combinational)
busy_a  out  1  scoreboard bit of raddr_a (combinational)
raddr_b  in  AW  read address B
rdata_b  out  XLEN  read data B (combinational)
busy_b  out  1  scoreboard bit of raddr_b (combinational)
sb_set  in  1  mark sb_addr busy (producer issued)
sb_addr  in  AW  scoreboard set address
clr_req  in  1  start clear sweep (1-cycle pulse or level)
clr_busy  out  1  sweep in progress
dbg_addr  in  AW  debug read address
dbg_data  out  XLEN  debug read data, registered

Behaviour:
- Reset (async): all registers 0, all busy bits 0, FSM IDLE, sweep index 1, dbg_data 0, clr_busy 0.
- Register 0 reads 0 and is never busy; writes and sb_set to address 0 are ignored.
- Addresses >= NREGS: writes and sb_set ignored; reads return 0 with busy 0.
- Writes take effect on the rising edge; both ports may write in the same cycle.
- Same address on both ports with both enables: port 1 wins.
- Scoreboard: sb_set sets busy[sb_addr] at the edge; any accepted write clears busy[waddr].
- sb_set and a write to the same address in one cycle: busy ends at 1 (set wins; a new producer is issued).
- Read ports return stored contents; same-cycle write data is visible only with the optional feature.
- Debug port: dbg_data <= value of reg[dbg_addr] at the clock edge. Latency 1 cycle. Uses stored contents, no bypass.
- Clear-sweep FSM, states IDLE and SWEEP:
  - IDLE: clr_req=1 -> SWEEP with idx=1.
  - SWEEP: each cycle reg[idx]<=0 and busy[idx]<=0, then idx++. After clearing idx=NREGS-1 -> IDLE, idx=1.
  - Sweep duration is NREGS-1 cycles. clr_busy=1 exactly while in SWEEP.
  - During SWEEP, we0/we1/sb_set are dropped (no effect) and clr_req is ignored.
  - Reads during SWEEP return current contents: already-swept registers read 0.
- Reset asserted mid-sweep: immediate return to IDLE, full reset values.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: read ports A/B forward same-cycle write data when an enabled port writes raddr (port 1 priority over port 0; never for address 0, never during SWEEP). busy_x is forced 0 when bypassing.
- Undefined: read ports return stored contents only. Same-cycle writes become visible in the next cycle.

Decomposition:
- Shared package regfile_pkg holds XLEN default, NREGS default, and the FSM state enum (ST_IDLE, ST_SWEEP).
- One sub-module, regfile_scoreboard: busy-bit array with set/clear priority and sweep clear, exposing busy_a/busy_b.
- Storage, write arbitration, sweep FSM and debug register live in regfile_mp.

Test Plan:
- we0=1 waddr0=5 wdata0=0xDEADBEEF; next cycle raddr_a=5 -> rdata_a=0xDEADBEEF; dbg_addr=5 -> dbg_data=0xDEADBEEF one cycle later.
- we0 and we1 both to addr 7 (0x11, 0x22) -> reg7=0x22. Write 0x55 to addr 0 -> rdata_a(addr 0)=0.
- sb_set addr 9 -> busy_a(raddr_a=9)=1. Write addr 9 -> busy 0 next cycle. sb_set plus write to addr 9 in the same cycle -> busy stays 1.
- Fill regs 1..31 with nonzero values, pulse clr_req -> clr_busy high for exactly 31 cycles, all regs read 0. A write issued mid-sweep is lost.
- Assert rst at sweep cycle 10 -> clr_busy=0 immediately, all regs 0, a fresh clr_req restarts from idx 1.
- With REGFILE_BYPASS_EN: we1 addr 3 data 0xABCD while raddr_b=3 -> rdata_b=0xABCD in the same cycle. Without the macro -> old value, then 0xABCD next cycle.
